// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_t;

   localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell used as the bit-slice of the serial adder.
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic c
);

   assign s = a ^ b ^ cin;
   assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock through a single fa cell.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   sa_state_t state, state_nx;

   logic [WIDTH-1:0] a_sr, b_sr;
   // Only WIDTH-1 sum bits need storing; the final bit comes straight from fa.
   logic [WIDTH-2:0] s_sr;
   logic [WIDTH-1:0] s_next;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             fa_s, fa_c;
   logic             load, step, finish;

   fa u_fa (
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .cin (carry),
      .s   (fa_s),
      .c   (fa_c)
   );

   assign s_next = {fa_s, s_sr};

   // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      load     = 1'b0;
      step     = 1'b0;
      finish   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == LAST_BIT) begin
               finish   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         s_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         if (load) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
         end else if (step) begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            s_sr  <= s_next[WIDTH-1:1];
            carry <= fa_c;
            cnt   <= cnt + CNT_W'(1);
         end
         if (finish) begin
            sum  <= s_next;
            cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // In the last RUN cycle, carry is the carry into the MSB.
            ovf  <= fa_c ^ carry;
`endif
         end
      end
   end

endmodule
